clock_divider_prog: RTL and testbench
=====================================

Name: clock_divider_prog

Overview:
Runtime-programmable integer clock divider, the parametrised successor of the fixed divide-by-2 toggle divider. It derives a divided clock and a one-cycle tick strobe from clk_in.
- Divisor can be changed on the fly; changes take effect only at period boundaries, so there are no runt pulses.
- Supports run/freeze enable and phase restart.
- Feeds slow peripherals and the display/CPU slow-clock domain; tick is the preferred clock-enable for logic that stays on clk_in.

Parameters:
CNT_W, 16, width of the divisor and the internal phase counter.
DEFAULT_DIV, 2, divisor in force after reset; legal range 2..2^CNT_W-1.

Ports:
clk_in  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  synchronous, active-low reset.
en  input  1  1 = run; 0 = freeze phase and clk_out, force tick low.
restart  input  1  one-cycle request to begin a new period on the next edge.
div_in  input  CNT_W  new divisor value.
div_load  input  1  capture div_in as the pending divisor.
clk_out  output  1  divided clock, registered.
tick  output  1  one-cycle strobe, high in the first cycle of each period.
div_active  output  CNT_W  divisor of the period currently running.
div_pend  output  1  a captured divisor is waiting for the next boundary.

Behaviour:
- Reset (rst_n=0 at an edge): phase=N-1 (idle-at-end), clk_out=0, tick=0, div_active=DEFAULT_DIV, div_pend=0, pending register=0. Reset mid-period discards any pending divisor.
- Clamp: any captured or applied divisor value of 0 or 1 becomes 2.
- Phase counter k runs 0..N-1, where N=div_active.
  - Each enabled edge: k <= (k==N-1 or restart) ? 0 : k+1.
  - A transition into k=0 is a "boundary".
- Registered outputs for the cycle where phase=k: clk_out=(k < H), where H=N-floor(N/2); tick=(k==0 and entered by an enabled edge).
  - Resulting waveform: high for ceil(N/2) cycles, low for floor(N/2).
  - N=2 gives a pure toggle identical to the legacy divider.
- First enabled edge after reset is a boundary: clk_out rises and tick=1 on that edge. No extra latency.
- en=0: k, clk_out, div_active and pending state hold; tick=0. Load capture still works. Resuming continues from the held phase; no boundary is forced.
- restart=1 with en=1: the next edge is a boundary regardless of k. clk_out goes 1, tick=1, and the pending divisor is applied. restart with en=0 is ignored (not remembered).
- Divisor selection at a boundary, in priority order:
  1. div_load=1 in the same cycle: use clamp(div_in).
  2. Else div_pend=1: use the pending value.
  3. Else keep div_active.
  - After a boundary, div_pend=0.
- div_load=1 at a non-boundary edge: pending <= clamp(div_in), div_pend <= 1. A later load before the boundary overwrites the earlier one (last wins).
- div_active changes only at boundaries; clk_out never produces a pulse shorter than min(ceil, floor) of the old or new N.
- Counter compare uses CNT_W bits. N=2^CNT_W-1 must run without overflow (k max = 2^CNT_W-2).
- rst_n takes priority over en, restart and div_load.

Test Plan:
1. Reset with DEFAULT_DIV=2, en=1 held → clk_out toggles every edge, starting 1 on the first edge; tick high every other cycle; div_active=2.
2. Load div_in=5 mid-period at N=2 → div_pend=1 until the next boundary. Then div_active=5, clk_out 3 cycles high / 2 low, tick every 5 cycles. No short pulse at the switch.
3. Load 7 then load 4 before the boundary → 4 applied, 7 never appears. Load div_in=1 → clamped, div_active=2.
4. N=6, drop en at k=2 for 10 cycles → clk_out frozen at 1, tick=0. On resume, 3 more cycles complete the period (k=3..5 low) before the next tick.
5. N=8, restart pulse at k=5 with div_load=1, div_in=3 in the same cycle → next edge: k=0, tick=1, clk_out=1, div_active=3.
6. rst_n=0 for one edge at k=4 with div_pend=1 → clk_out=0, tick=0, div_pend=0, div_active=DEFAULT_DIV; resumes from the first boundary.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider: produces a registered divided clock
// and a first-cycle-of-period tick from clk_in, with glitch-free divisor changes.
module clock_divider_prog #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_active,
    output logic             div_pend
);

    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_N = (CNT_W'(DEFAULT_DIV) < TWO) ? TWO : CNT_W'(DEFAULT_DIV);

    // Divisors below 2 cannot form a period with both a high and a low phase.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < TWO) ? TWO : v;
    endfunction

    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] div_in_c;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] n_sel;
    logic [CNT_W-1:0] half_hi;
    logic [CNT_W-1:0] phase_next;
    logic             last;
    logic             boundary;

    always_comb begin
        div_in_c = clamp_div(div_in);
        last     = (phase == div_active - ONE);
        boundary = en && (restart || last);

        // A load in the boundary cycle itself beats an older pending value.
        if (div_load) begin
            div_next = div_in_c;
        end else if (div_pend) begin
            div_next = pend_val;
        end else begin
            div_next = div_active;
        end

        n_sel      = boundary ? div_next : div_active;
        half_hi    = n_sel - (n_sel >> 1);
        phase_next = boundary ? '0 : phase + ONE;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            phase      <= DEF_N - ONE;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            div_active <= DEF_N;
            div_pend   <= 1'b0;
            pend_val   <= '0;
        end else begin
            tick <= boundary;
            if (en) begin
                phase   <= phase_next;
                clk_out <= (phase_next < half_hi);
            end
            if (boundary) begin
                div_active <= div_next;
                div_pend   <= 1'b0;
            end else if (div_load) begin
                pend_val <= div_in_c;
                div_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: a behavioural model feeds an expected-value queue
// checked every edge, plus directed checks of each scenario.
module tb_clock_divider_prog;

    localparam int CNT_W = 16;
    localparam int DEF   = 2;
    localparam int SBW   = CNT_W + 3;

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             restart = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic             div_load = 1'b0;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] div_active;
    logic             div_pend;

    clock_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .restart    (restart),
        .div_in     (div_in),
        .div_load   (div_load),
        .clk_out    (clk_out),
        .tick       (tick),
        .div_active (div_active),
        .div_pend   (div_pend)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    logic [SBW-1:0] exp_q[$];

    // Model state, written from the behavioural description.
    int   m_k = DEF - 1;
    int   m_n = DEF;
    int   m_pv = 0;
    logic m_pend = 1'b0;
    logic m_clk = 1'b0;
    logic m_tick = 1'b0;

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Drive one edge worth of inputs, predict its outcome, wait past the edge.
    task automatic step(input logic e, input logic r, input logic l, input int d, input logic rn);
        logic [CNT_W-1:0] nv;
        en = e; restart = r; div_load = l; div_in = d[CNT_W-1:0]; rst_n = rn;
        if (!rn) begin
            m_k = DEF - 1; m_n = DEF; m_pv = 0; m_pend = 0; m_clk = 0; m_tick = 0;
        end else if (!e) begin
            m_tick = 0;
            if (l) begin m_pv = clampv(d); m_pend = 1; end
        end else begin
            if (r || m_k == m_n - 1) begin
                if (l) m_n = clampv(d);
                else if (m_pend) m_n = m_pv;
                m_pend = 0; m_k = 0; m_tick = 1;
            end else begin
                m_k = m_k + 1; m_tick = 0;
                if (l) begin m_pv = clampv(d); m_pend = 1; end
            end
            m_clk = (m_k < m_n - m_n / 2);
        end
        nv = m_n[CNT_W-1:0];
        exp_q.push_back({m_clk, m_tick, nv, m_pend});
        @(posedge clk_in);
        #1;
    endtask

    always @(posedge clk_in) begin
        logic [SBW-1:0] obs, expv;
        #1;
        if (exp_q.size() > 0) begin
            obs  = {clk_out, tick, div_active, div_pend};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL sb t=%0t got clk=%b tick=%b div=%0d pend=%b want clk=%b tick=%b div=%0d pend=%b",
                         $time, obs[SBW-1], obs[SBW-2], obs[CNT_W:1], obs[0],
                         expv[SBW-1], expv[SBW-2], expv[CNT_W:1], expv[0]);
            end
        end
    end

    task automatic test_reset;
        step(0, 0, 0, 0, 0);
        checks++;
        if ({clk_out, tick, div_active, div_pend} !== {1'b0, 1'b0, 16'd2, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got clk=%b tick=%b div=%0d pend=%b want 0 0 2 0",
                     clk_out, tick, div_active, div_pend);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0, 1);
            checks++;
            if (clk_out !== (i % 2 == 0) || tick !== (i % 2 == 0) || div_active !== 16'd2) begin
                errors++;
                $display("FAIL div2_toggle cyc=%0d got clk=%b tick=%b div=%0d want clk=tick=%b div=2",
                         i, clk_out, tick, div_active, (i % 2 == 0));
            end
        end
    endtask

    task automatic test_load;
        int highs, ticks;
        step(1, 0, 0, 0, 1);
        step(1, 0, 1, 5, 1);
        checks++;
        if (div_pend !== 1'b1 || div_active !== 16'd2) begin
            errors++;
            $display("FAIL load_pending got pend=%b div=%0d want pend=1 div=2", div_pend, div_active);
        end
        step(1, 0, 0, 0, 1);
        checks++;
        if (div_active !== 16'd5 || div_pend !== 1'b0 || tick !== 1'b1 || clk_out !== 1'b1) begin
            errors++;
            $display("FAIL load_apply got div=%0d pend=%b tick=%b clk=%b want 5 0 1 1",
                     div_active, div_pend, tick, clk_out);
        end
        highs = 0; ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 1);
            highs += int'(clk_out);
            ticks += int'(tick);
        end
        checks++;
        if (highs != 6 || ticks != 2) begin
            errors++;
            $display("FAIL div5_shape got highs=%0d ticks=%0d want highs=6 ticks=2", highs, ticks);
        end
    endtask

    task automatic test_last_wins;
        bit seen;
        step(1, 0, 1, 7, 1);
        step(1, 0, 1, 4, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 0, 0, 0, 1);
            if (tick) seen = 1;
            checks++;
            if (div_active !== (tick ? 16'd4 : 16'd5)) begin
                errors++;
                $display("FAIL last_wins got div=%0d tick=%b want %0d", div_active, tick, tick ? 4 : 5);
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL last_wins_timeout got no tick want tick"); end
        step(1, 0, 1, 1, 1);
        checks++;
        if (div_pend !== 1'b1) begin
            errors++;
            $display("FAIL clamp_pending got pend=%b want 1", div_pend);
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 0, 0, 0, 1);
            if (tick) seen = 1;
        end
        checks++;
        if (!seen || div_active !== 16'd2) begin
            errors++;
            $display("FAIL clamp_apply got div=%0d tick_seen=%0d want div=2 tick_seen=1", div_active, seen);
        end
    endtask

    task automatic test_freeze;
        step(1, 0, 1, 6, 1);
        step(1, 0, 0, 0, 1);
        checks++;
        if (div_active !== 16'd6 || tick !== 1'b1) begin
            errors++;
            $display("FAIL freeze_setup got div=%0d tick=%b want 6 1", div_active, tick);
        end
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 1);
            checks++;
            if (clk_out !== 1'b1 || tick !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold cyc=%0d got clk=%b tick=%b want 1 0", i, clk_out, tick);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1);
            checks++;
            if (clk_out !== 1'b0 || tick !== 1'b0) begin
                errors++;
                $display("FAIL freeze_resume cyc=%0d got clk=%b tick=%b want 0 0", i, clk_out, tick);
            end
        end
        step(1, 0, 0, 0, 1);
        checks++;
        if (clk_out !== 1'b1 || tick !== 1'b1) begin
            errors++;
            $display("FAIL freeze_next_tick got clk=%b tick=%b want 1 1", clk_out, tick);
        end
    endtask

    task automatic test_restart;
        bit seen;
        step(1, 0, 1, 8, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 0, 0, 0, 1);
            if (tick) seen = 1;
        end
        checks++;
        if (!seen || div_active !== 16'd8) begin
            errors++;
            $display("FAIL restart_setup got div=%0d tick_seen=%0d want 8 1", div_active, seen);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
        step(1, 1, 1, 3, 1);
        checks++;
        if (tick !== 1'b1 || clk_out !== 1'b1 || div_active !== 16'd3 || div_pend !== 1'b0) begin
            errors++;
            $display("FAIL restart_load got tick=%b clk=%b div=%0d pend=%b want 1 1 3 0",
                     tick, clk_out, div_active, div_pend);
        end
    endtask

    task automatic test_reset_mid;
        step(1, 1, 1, 8, 1);
        step(1, 0, 1, 5, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        checks++;
        if (div_pend !== 1'b1 || div_active !== 16'd8 || clk_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_setup got pend=%b div=%0d clk=%b want 1 8 0", div_pend, div_active, clk_out);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if ({clk_out, tick, div_active, div_pend} !== {1'b0, 1'b0, 16'd2, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got clk=%b tick=%b div=%0d pend=%b want 0 0 2 0",
                     clk_out, tick, div_active, div_pend);
        end
        step(1, 0, 0, 0, 1);
        checks++;
        if (tick !== 1'b1 || clk_out !== 1'b1 || div_active !== 16'd2) begin
            errors++;
            $display("FAIL reset_mid_resume got tick=%b clk=%b div=%0d want 1 1 2", tick, clk_out, div_active);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 9)), $urandom_range(0, 63) != 0);
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_last_wins;
        test_freeze;
        test_restart;
        test_reset_mid;
        test_random;
        @(posedge clk_in);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
